// File: rtl/param_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// param_universal_shift_reg
//
// Parametrised universal shift register. It supports hold, logical shift
// left/right, rotate left/right, arithmetic shift right and parallel load.
//
// It has two operating styles:
//   - Free-running: while idle, the selected mode step is applied every clock.
//   - Counted: a start/busy/done handshake applies `shamt` steps of a shift
//     mode, one step per clock.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset (control and data)
//   mode          in   operation select:
//                        000 hold, 001 SRL, 010 SLL, 011 load,
//                        100 ROR,  101 ROL, 110 SRA, 111 hold
//   shift_in_r    in   serial bit entering the MSB on SRL
//   shift_in_l    in   serial bit entering the LSB on SLL
//   data_in       in   parallel load value
//   start         in   begin a counted operation (sampled only in IDLE)
//   shamt         in   step count for a counted operation
//   data_out      out  register contents
//   serial_out_r  out  data_out[0]
//   serial_out_l  out  data_out[WIDTH-1]
//   busy          out  high while a counted operation is running
//   done          out  one-cycle pulse when a counted operation completes
// -----------------------------------------------------------------------------
module param_universal_shift_reg #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         mode,
    input  logic               shift_in_r,
    input  logic               shift_in_l,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               start,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   data_out,
    output logic               serial_out_r,
    output logic               serial_out_l,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SRL  = 3'b001;
    localparam logic [2:0] MODE_SLL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_SRA  = 3'b110;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [2:0]         mode_q,  mode_d;
    logic [SHAMT_W-1:0] count_q, count_d;

    // One step of the selected operation applied to the current contents.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] q,
        input logic             sir,
        input logic             sil,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SRL:  r = {sir, q[WIDTH-1:1]};
            MODE_SLL:  r = {q[WIDTH-2:0], sil};
            MODE_LOAD: r = din;
            MODE_ROR:  r = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  r = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_SRA:  r = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   r = q;
        endcase
        return r;
    endfunction

    // Only true shift/rotate modes may be run as a counted operation.
    // Hold, load and the reserved code complete immediately.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SRL) || (m == MODE_SLL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_SRA);
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // The start edge itself never modifies the data.
                    if (is_shift_mode(mode) && (shamt != '0)) begin
                        mode_d  = mode;
                        count_d = shamt;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    data_d = step_fn(mode, data_q, shift_in_r, shift_in_l, data_in);
                end
            end
            S_RUN: begin
                // Serial inputs are taken live. Load cannot be latched, so
                // data_in is irrelevant here.
                data_d  = step_fn(mode_q, data_q, shift_in_r, shift_in_l, data_q);
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            mode_q  <= MODE_HOLD;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    assign data_out     = data_q;
    assign serial_out_r = data_q[0];
    assign serial_out_l = data_q[WIDTH-1];
    assign busy         = (state_q == S_RUN);
    assign done         = (state_q == S_DONE);

endmodule
